exc_ctrl: RTL and testbench

Exception controller for the single-cycle/pipelined LEGv8 core. It consumes the decoder's NotAnInstr and ERet flags and an external interrupt request. It saves the return address and exception syndrome, redirects fetch to the exception vector, and services ERET. It sits beside the decode stage and feeds the fetch PC mux and the MRS read path.

---
 rtl/exc_ctrl.sv | 142 ++++++++++++++
 tb/tb_exc_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception controller for the LEGv8 core: takes invalid-opcode, ERET and
// external-interrupt events from decode, records return address and syndrome,
// and issues one-cycle fetch redirects to the exception vector or back to ELR.
module exc_ctrl #(
  parameter int unsigned    N          = 64,
  parameter logic [N-1:0]   EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Valid_ID,
  input  logic         NotAnInstr,
  input  logic         ERet,
  input  logic         ExtIRQ,
  input  logic [N-1:0] PC_ID,
  input  logic [1:0]   SysRegSel,
  output logic         Exc,
  output logic [N-1:0] EVAddr,
  output logic         ERetTaken,
  output logic         ExtIAck,
  output logic [N-1:0] ELR,
  output logic [N-1:0] ESR,
  output logic [N-1:0] SysRegOut,
  output logic         InHandler,
  output logic         Halted
);

  typedef enum logic [1:0] {StIdle, StHandler, StLocked} state_e;

  localparam logic [3:0] EscUndef = 4'h1;
  localparam logic [3:0] EscIrq   = 4'h2;
  localparam logic [3:0] EscERet  = 4'h3;

  state_e       state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic         exc_q, exc_d;
  logic         eret_q, eret_d;
  logic         ack_q, ack_d;
  logic         blackout_q, blackout_d;

  // Events are suppressed while a redirect pulse is flushing decode and for the
  // following blackout cycle, so the wrong-path instruction never triggers
  // anything and a still-pending IRQ is taken no earlier than 3 edges later.
  logic quiet, dec_ok, irq_ok;

  // Event qualification.
  always_comb begin
    quiet  = exc_q | eret_q | blackout_q;
    dec_ok = Valid_ID & ~quiet;
    irq_ok = ExtIRQ & ~quiet;
  end

  // Next-state, saved-context and pulse logic.
  always_comb begin
    state_d    = state_q;
    elr_d      = elr_q;
    esr_d      = esr_q;
    exc_d      = 1'b0;
    eret_d     = 1'b0;
    ack_d      = 1'b0;
    blackout_d = exc_q | eret_q;
    case (state_q)
      StIdle: begin
        if (dec_ok && NotAnInstr) begin
          elr_d   = PC_ID;
          esr_d   = EscUndef;
          exc_d   = 1'b1;
          state_d = StHandler;
        end else if (dec_ok && ERet) begin
          // ERET outside a handler is itself an exception.
          elr_d   = PC_ID;
          esr_d   = EscERet;
          exc_d   = 1'b1;
          state_d = StHandler;
        end else if (irq_ok) begin
          // PC_ID is saved even for a bubble so the instruction restarts.
          elr_d   = PC_ID;
          esr_d   = EscIrq;
          exc_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = StHandler;
        end
      end
      StHandler: begin
        // Double fault wins over ERET; interrupts stay masked here.
        if (dec_ok && NotAnInstr) begin
          state_d = StLocked;
        end else if (dec_ok && ERet) begin
          eret_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StLocked: begin
        state_d = StLocked;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and context registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      elr_q      <= '0;
      esr_q      <= '0;
      exc_q      <= 1'b0;
      eret_q     <= 1'b0;
      ack_q      <= 1'b0;
      blackout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      elr_q      <= elr_d;
      esr_q      <= esr_d;
      exc_q      <= exc_d;
      eret_q     <= eret_d;
      ack_q      <= ack_d;
      blackout_q <= blackout_d;
    end
  end

  // MRS read mux reflects register contents before the current edge.
  always_comb begin
    SysRegOut = '0;
    case (SysRegSel)
      2'b00:   SysRegOut = elr_q;
      2'b01:   SysRegOut = {{(N-4){1'b0}}, esr_q};
      default: SysRegOut = '0;
    endcase
  end

  assign Exc       = exc_q;
  assign ERetTaken = eret_q;
  assign ExtIAck   = ack_q;
  assign EVAddr    = EXC_VECTOR;
  assign ELR       = elr_q;
  assign ESR       = {{(N-4){1'b0}}, esr_q};
  assign InHandler = (state_q == StHandler);
  assign Halted    = (state_q == StLocked);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid_ID, NotAnInstr, ERet, ExtIRQ;
  logic [63:0] PC_ID;
  logic [1:0]  SysRegSel;
  logic        Exc, ERetTaken, ExtIAck, InHandler, Halted;
  logic [63:0] EVAddr, ELR, ESR, SysRegOut;

  int n_cmp = 0;
  int n_bad = 0;

  exc_ctrl #(.N(64), .EXC_VECTOR(64'hD8)) dut (
    .clk        (clk),
    .reset      (reset),
    .Valid_ID   (Valid_ID),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .ExtIRQ     (ExtIRQ),
    .PC_ID      (PC_ID),
    .SysRegSel  (SysRegSel),
    .Exc        (Exc),
    .EVAddr     (EVAddr),
    .ERetTaken  (ERetTaken),
    .ExtIAck    (ExtIAck),
    .ELR        (ELR),
    .ESR        (ESR),
    .SysRegOut  (SysRegOut),
    .InHandler  (InHandler),
    .Halted     (Halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Valid_ID   = 1'b0;
    NotAnInstr = 1'b0;
    ERet       = 1'b0;
    ExtIRQ     = 1'b0;
  endtask

  initial begin
    idle_inputs();
    PC_ID     = 64'h0;
    SysRegSel = 2'b00;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_exc", Exc, 0);
    check("rst_eret", ERetTaken, 0);
    check("rst_ack", ExtIAck, 0);
    check("rst_elr", ELR, 0);
    check("rst_esr", ESR, 0);
    check("rst_inh", InHandler, 0);
    check("rst_halt", Halted, 0);
    check("rst_evaddr", EVAddr, 64'hD8);

    // Undefined instruction in IDLE; held flag is ignored while flushing.
    Valid_ID = 1'b1; NotAnInstr = 1'b1; PC_ID = 64'h40;
    tick();
    check("undef_exc", Exc, 1);
    check("undef_elr", ELR, 64'h40);
    check("undef_esr", ESR, 1);
    check("undef_inh", InHandler, 1);
    tick();
    check("undef_exc_once", Exc, 0);
    check("undef_nohalt1", Halted, 0);
    tick();
    check("undef_nohalt2", Halted, 0);
    NotAnInstr = 1'b0;

    // ERET from handler.
    ERet = 1'b1;
    tick();
    ERet = 1'b0; Valid_ID = 1'b0;
    check("eret_taken", ERetTaken, 1);
    check("eret_inh", InHandler, 0);
    check("eret_elr", ELR, 64'h40);
    check("eret_noexc", Exc, 0);
    SysRegSel = 2'b00; #1 check("mrs_elr", SysRegOut, 64'h40);
    SysRegSel = 2'b01; #1 check("mrs_esr", SysRegOut, 1);
    SysRegSel = 2'b10; #1 check("mrs_zero", SysRegOut, 0);
    tick();
    check("eret_once", ERetTaken, 0);
    tick();

    // IRQ held from inside a handler through ERET.
    Valid_ID = 1'b1; NotAnInstr = 1'b1; PC_ID = 64'h50;
    tick();
    check("h2_exc", Exc, 1);
    idle_inputs();
    ExtIRQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("irq_masked_ack", ExtIAck, 0);
      check("irq_masked_inh", InHandler, 1);
    end
    Valid_ID = 1'b1; ERet = 1'b1; PC_ID = 64'h80;
    tick();
    ERet = 1'b0; Valid_ID = 1'b0;
    check("irq_eret", ERetTaken, 1);
    check("irq_eret_ack", ExtIAck, 0);
    tick();
    check("irq_bo1_exc", Exc, 0);
    tick();
    check("irq_bo2_exc", Exc, 0);
    check("irq_bo2_ack", ExtIAck, 0);
    tick();
    check("irq_exc", Exc, 1);
    check("irq_ack", ExtIAck, 1);
    check("irq_elr", ELR, 64'h80);
    check("irq_esr", ESR, 2);
    ExtIRQ = 1'b0;
    tick();
    check("irq_ack_once", ExtIAck, 0);
    tick();
    Valid_ID = 1'b1; ERet = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();

    // Priority: NotAnInstr beats ExtIRQ on the same edge.
    Valid_ID = 1'b1; NotAnInstr = 1'b1; ExtIRQ = 1'b1; PC_ID = 64'h10;
    tick();
    idle_inputs();
    check("pri_exc", Exc, 1);
    check("pri_esr", ESR, 1);
    check("pri_ack", ExtIAck, 0);
    check("pri_elr", ELR, 64'h10);
    tick();
    tick();

    // Double fault locks; ERET ignored; reset recovers and beats events.
    Valid_ID = 1'b1; NotAnInstr = 1'b1; PC_ID = 64'h60;
    tick();
    NotAnInstr = 1'b0;
    check("dbl_halt", Halted, 1);
    check("dbl_noexc", Exc, 0);
    check("dbl_elr", ELR, 64'h10);
    ERet = 1'b1;
    tick();
    check("lock_eret", ERetTaken, 0);
    check("lock_halt", Halted, 1);
    ERet = 1'b0;
    reset = 1'b1; NotAnInstr = 1'b1; PC_ID = 64'h99;
    tick();
    reset = 1'b0;
    idle_inputs();
    check("rst2_halt", Halted, 0);
    check("rst2_inh", InHandler, 0);
    check("rst2_elr", ELR, 0);
    check("rst2_esr", ESR, 0);
    check("rst2_exc", Exc, 0);

    // Flags on a bubble are ignored.
    NotAnInstr = 1'b1; PC_ID = 64'h30;
    tick();
    NotAnInstr = 1'b0;
    check("bubble_exc", Exc, 0);
    check("bubble_inh", InHandler, 0);

    // ERET outside a handler.
    Valid_ID = 1'b1; ERet = 1'b1; PC_ID = 64'h20;
    tick();
    idle_inputs();
    check("ill_eret_exc", Exc, 1);
    check("ill_eret_esr", ESR, 3);
    check("ill_eret_elr", ELR, 64'h20);
    check("ill_eret_taken", ERetTaken, 0);
    check("ill_eret_inh", InHandler, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
